// File: rtl/l2_sram_pkg.sv
// Shared constants and read-response type for the L2 data-array port controller.
// L2_SRAM_RSP_SKID_EN selects a 2-entry response buffer; otherwise it is a single register.
package l2_sram_pkg;

    localparam int L2_DATA_W  = 128;
    localparam int L2_ADDR_W  = 7;
    localparam int L2_WMASK_W = L2_DATA_W / 8;
    localparam int L2_ID_W    = 4;

`ifdef L2_SRAM_RSP_SKID_EN
    localparam int RSP_DEPTH = 2;
`else
    localparam int RSP_DEPTH = 1;
`endif

    typedef struct packed {
        logic [L2_DATA_W-1:0] rdata;
        logic [L2_ID_W-1:0]   id;
    } l2_rd_rsp_t;

endpackage

// File: rtl/l2_sram_rsp_fifo.sv
// Small in-order response buffer (1 or 2 entries).
// Push and pop may coincide, even when full, because the pop frees the slot being refilled.
module l2_sram_rsp_fifo #(
    parameter int WIDTH = 132,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;
    logic             w_wr_ptr_nxt;
    logic             w_rd_ptr_nxt;

    // With a single entry both pointers stay pinned to slot 0.
    assign w_wr_ptr_nxt = (DEPTH > 1) ? ~r_wr_ptr : 1'b0;
    assign w_rd_ptr_nxt = (DEPTH > 1) ? ~r_rd_ptr : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/l2_sram_port_ctrl.sv
// Drives a 0rw1r1w OpenRAM L2 data array from independent write/read request channels.
// L2_SRAM_RSP_SKID_EN (via l2_sram_pkg::RSP_DEPTH) sets response buffer depth 2, else 1.
module l2_sram_port_ctrl
    import l2_sram_pkg::*;
#(
    parameter int DATA_WIDTH = L2_DATA_W,
    parameter int ADDR_WIDTH = L2_ADDR_W,
    parameter int NUM_WMASKS = L2_WMASK_W,
    parameter int ID_WIDTH   = L2_ID_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WMASKS-1:0] wr_wmask,
    input  logic [DATA_WIDTH-1:0] wr_wdata,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ID_WIDTH-1:0]   rd_id,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int RSP_W = DATA_WIDTH + ID_WIDTH;

    logic                r_vld_p1;
    logic [ID_WIDTH-1:0] r_id_p1;
    logic                w_conflict;
    logic                w_pop;
    logic                w_rd_fire;
    logic [1:0]          w_occ;
    logic [2:0]          w_proj_occ;
    logic [RSP_W-1:0]    w_head;

    assign wr_ready    = rst_n;
    assign sram_csb0   = !(wr_valid && wr_ready);
    assign sram_addr0  = wr_addr;
    assign sram_wmask0 = wr_wmask;
    assign sram_din0   = wr_wdata;

    // The macro cannot read and write one word in the same cycle; the write wins.
    assign w_conflict = wr_valid && rd_valid && (wr_addr == rd_addr);
    assign w_pop      = rsp_valid && rsp_ready;

    // A read is accepted only if its response is guaranteed a buffer slot.
    assign w_proj_occ = {1'b0, w_occ} + {2'b00, r_vld_p1} - {2'b00, w_pop};
    assign rd_ready   = rst_n && !w_conflict && (w_proj_occ < 3'(RSP_DEPTH));
    assign w_rd_fire  = rd_valid && rd_ready;
    assign sram_csb1  = !w_rd_fire;
    assign sram_addr1 = rd_addr;

    // Stage p1: macro read in flight, sram_dout1 valid at the end of this cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_rd_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_fire) begin
            r_id_p1 <= rd_id;
        end
    end

    l2_sram_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_vld_p1),
        .i_data ({sram_dout1, r_id_p1}),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    assign rsp_valid = (w_occ != 2'd0);
    assign rsp_rdata = w_head[RSP_W-1 -: DATA_WIDTH];
    assign rsp_id    = w_head[ID_WIDTH-1:0];

endmodule
